matrix_stack: RTL and testbench

MATRIX_STACK -- requirements
Module: matrix_stack

---
 rtl/matrix_stack_pkg.sv | 31 +++
 rtl/matrix_stack_bank.sv | 93 +++++++++
 rtl/matrix_stack.sv | 211 +++++++++++++++++++++
 tb/tb_matrix_stack.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_stack_pkg.sv
// matrix_stack_pkg -- shared definitions for the matrix stack block.
// Contents: command opcode encoding, load FSM state encoding, the IEEE-754
// single-precision 1.0 constant and the four identity rows (row 0 in MSB lane).
// Optional feature macro used by the block: MATRIX_STACK_ERR_EN.
package matrix_stack_pkg;

   // Opcodes 6 and 7 are not listed and decode as NOP.
   typedef enum logic [2:0] {
      OP_NOP     = 3'd0,
      OP_LOAD_ID = 3'd1,
      OP_LOAD    = 3'd2,
      OP_PUSH    = 3'd3,
      OP_POP     = 3'd4,
      OP_WRITE   = 3'd5
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_R0 = 3'd1,
      ST_LOAD_R1 = 3'd2,
      ST_LOAD_R2 = 3'd3,
      ST_LOAD_R3 = 3'd4
   } state_e;

   localparam logic [31:0]  FP_ONE   = 32'h3F80_0000;
   localparam logic [127:0] ID_ROW_0 = {FP_ONE, 96'h0};
   localparam logic [127:0] ID_ROW_1 = {32'h0, FP_ONE, 64'h0};
   localparam logic [127:0] ID_ROW_2 = {64'h0, FP_ONE, 32'h0};
   localparam logic [127:0] ID_ROW_3 = {96'h0, FP_ONE};

endpackage

// File: rtl/matrix_stack_bank.sv
// matrix_stack_bank -- one stack of DEPTH 4-row matrices with its pointer.
// Ports: clk/rst (async active-high); push_en/pop_en single-cycle stack ops;
// wr_all_en + wr_row_0..3 overwrite all rows of the top; row_we/row_idx/
// row_data overwrite a single row of the top; top_0..3 and sp expose the top
// combinationally; ovf_evt/unf_evt pulse when a push/pop is refused.
// At most one of push_en, pop_en, wr_all_en, row_we is high in a cycle.
module matrix_stack_bank
   import matrix_stack_pkg::*;
#(
   parameter int ROW_W = 128,
   parameter int DEPTH = 32,
   localparam int SP_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_en,
   input  logic             pop_en,
   input  logic             wr_all_en,
   input  logic [ROW_W-1:0] wr_row_0,
   input  logic [ROW_W-1:0] wr_row_1,
   input  logic [ROW_W-1:0] wr_row_2,
   input  logic [ROW_W-1:0] wr_row_3,
   input  logic             row_we,
   input  logic [1:0]       row_idx,
   input  logic [ROW_W-1:0] row_data,
   output logic [ROW_W-1:0] top_0,
   output logic [ROW_W-1:0] top_1,
   output logic [ROW_W-1:0] top_2,
   output logic [ROW_W-1:0] top_3,
   output logic [SP_W-1:0]  sp,
   output logic             ovf_evt,
   output logic             unf_evt
);

   localparam logic [ROW_W-1:0] ID_ROWS [4] = '{ROW_W'(ID_ROW_0), ROW_W'(ID_ROW_1),
                                                ROW_W'(ID_ROW_2), ROW_W'(ID_ROW_3)};

   logic [ROW_W-1:0] mem_q [DEPTH][4];
   logic [ROW_W-1:0] mem_d [DEPTH][4];
   logic [SP_W-1:0]  sp_q, sp_d, sp_inc_s;

   // Next-state of storage and pointer for the single operation of this cycle.
   always_comb begin
      mem_d    = mem_q;
      sp_d     = sp_q;
      ovf_evt  = 1'b0;
      unf_evt  = 1'b0;
      sp_inc_s = sp_q + SP_W'(1);
      if (push_en) begin
         if (sp_q == SP_W'(DEPTH - 1)) begin
            ovf_evt = 1'b1;
         end else begin
            sp_d = sp_inc_s;
            for (int r = 0; r < 4; r++) mem_d[sp_inc_s][r] = mem_q[sp_q][r];
         end
      end else if (pop_en) begin
         if (sp_q == '0) begin
            unf_evt = 1'b1;
         end else begin
            sp_d = sp_q - SP_W'(1);
         end
      end else if (wr_all_en) begin
         mem_d[sp_q][0] = wr_row_0;
         mem_d[sp_q][1] = wr_row_1;
         mem_d[sp_q][2] = wr_row_2;
         mem_d[sp_q][3] = wr_row_3;
      end else if (row_we) begin
         mem_d[sp_q][row_idx] = row_data;
      end else begin
         mem_d = mem_q;
      end
   end

   // Storage registers; reset restores identity everywhere so an aborted load leaves nothing behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q <= '0;
         for (int e = 0; e < DEPTH; e++) begin
            for (int r = 0; r < 4; r++) mem_q[e][r] <= ID_ROWS[r];
         end
      end else begin
         sp_q  <= sp_d;
         mem_q <= mem_d;
      end
   end

   assign top_0 = mem_q[sp_q][0];
   assign top_1 = mem_q[sp_q][1];
   assign top_2 = mem_q[sp_q][2];
   assign top_3 = mem_q[sp_q][3];
   assign sp    = sp_q;

endmodule

// File: rtl/matrix_stack.sv
// matrix_stack -- NUM_STACKS independent matrix stacks with a command FSM.
// Ports: clk, rst (async active-high); mode selects the stack for commands and
// peek; cmd_valid/cmd_op/cmd_ready command handshake; data_in/data_valid row
// beats for LOAD; write_in_0..3 full-matrix WRITE data; peek_out_0..3 and
// depth_out show the top of stack[mode]; overflow/underflow sticky error flags.
// Macro MATRIX_STACK_ERR_EN enables the error flags (otherwise tied low).
module matrix_stack
   import matrix_stack_pkg::*;
#(
   parameter int ROW_W      = 128,
   parameter int DEPTH      = 32,
   parameter int NUM_STACKS = 2,
   localparam int SEL_W     = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1,
   localparam int SP_W      = $clog2(DEPTH),
   localparam int DEP_W     = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] mode,
   input  logic             cmd_valid,
   input  logic [2:0]       cmd_op,
   output logic             cmd_ready,
   input  logic [ROW_W-1:0] data_in,
   input  logic             data_valid,
   input  logic [ROW_W-1:0] write_in_0,
   input  logic [ROW_W-1:0] write_in_1,
   input  logic [ROW_W-1:0] write_in_2,
   input  logic [ROW_W-1:0] write_in_3,
   output logic [ROW_W-1:0] peek_out_0,
   output logic [ROW_W-1:0] peek_out_1,
   output logic [ROW_W-1:0] peek_out_2,
   output logic [ROW_W-1:0] peek_out_3,
   output logic [DEP_W-1:0] depth_out,
   output logic             overflow,
   output logic             underflow
);

   state_e           state_q, state_d;
   logic             ready_q, ready_d;
   logic [SEL_W-1:0] tgt_q, tgt_d;
   logic             ld_id_s, ld_s, push_s, pop_s, wr_s;
   logic             row_we_s;
   logic [1:0]       row_idx_s;
   logic [ROW_W-1:0] wa_s [4];
   logic [ROW_W-1:0] top_s [NUM_STACKS][4];
   logic [SP_W-1:0]  sp_s [NUM_STACKS];
   logic [NUM_STACKS-1:0] ovf_evt_s, unf_evt_s;

   // Command decode; only an accepted command (valid while idle) has any effect.
   always_comb begin
      ld_id_s = 1'b0;
      ld_s    = 1'b0;
      push_s  = 1'b0;
      pop_s   = 1'b0;
      wr_s    = 1'b0;
      if (cmd_valid && (state_q == ST_IDLE)) begin
         case (cmd_op_e'(cmd_op))
            OP_LOAD_ID: ld_id_s = 1'b1;
            OP_LOAD:    ld_s    = 1'b1;
            OP_PUSH:    push_s  = 1'b1;
            OP_POP:     pop_s   = 1'b1;
            OP_WRITE:   wr_s    = 1'b1;
            default:    ld_id_s = 1'b0;
         endcase
      end else begin
         ld_id_s = 1'b0;
      end
   end

   // LOAD_ID reuses the full-matrix write path with identity data.
   always_comb begin
      if (ld_id_s) begin
         wa_s[0] = ROW_W'(ID_ROW_0);
         wa_s[1] = ROW_W'(ID_ROW_1);
         wa_s[2] = ROW_W'(ID_ROW_2);
         wa_s[3] = ROW_W'(ID_ROW_3);
      end else begin
         wa_s[0] = write_in_0;
         wa_s[1] = write_in_1;
         wa_s[2] = write_in_2;
         wa_s[3] = write_in_3;
      end
   end

   // Load FSM next state: each data_valid beat writes one row and advances; no beat stalls.
   always_comb begin
      state_d   = state_q;
      tgt_d     = tgt_q;
      row_we_s  = 1'b0;
      row_idx_s = 2'd0;
      case (state_q)
         ST_IDLE: begin
            if (ld_s) begin
               state_d = ST_LOAD_R0;
               tgt_d   = mode;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD_R0, ST_LOAD_R1, ST_LOAD_R2, ST_LOAD_R3: begin
            if (data_valid) begin
               row_we_s  = 1'b1;
               row_idx_s = 2'(state_q - ST_LOAD_R0);
               state_d   = (state_q == ST_LOAD_R3) ? ST_IDLE : state_e'(state_q + 3'd1);
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   // FSM state, latched load target and registered ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         tgt_q   <= tgt_d;
      end
   end

   assign cmd_ready = ready_q;

   // Single-cycle commands target mode directly; LOAD beats target the latched stack.
   for (genvar i = 0; i < NUM_STACKS; i++) begin : g_bank
      logic hit_cmd_s, hit_row_s;
      assign hit_cmd_s = (mode == SEL_W'(i));
      assign hit_row_s = (tgt_q == SEL_W'(i));
      matrix_stack_bank #(.ROW_W(ROW_W), .DEPTH(DEPTH)) u_bank (
         .clk       (clk),
         .rst       (rst),
         .push_en   (push_s && hit_cmd_s),
         .pop_en    (pop_s && hit_cmd_s),
         .wr_all_en ((ld_id_s || wr_s) && hit_cmd_s),
         .wr_row_0  (wa_s[0]),
         .wr_row_1  (wa_s[1]),
         .wr_row_2  (wa_s[2]),
         .wr_row_3  (wa_s[3]),
         .row_we    (row_we_s && hit_row_s),
         .row_idx   (row_idx_s),
         .row_data  (data_in),
         .top_0     (top_s[i][0]),
         .top_1     (top_s[i][1]),
         .top_2     (top_s[i][2]),
         .top_3     (top_s[i][3]),
         .sp        (sp_s[i]),
         .ovf_evt   (ovf_evt_s[i]),
         .unf_evt   (unf_evt_s[i])
      );
   end

   // Peek/depth mux for the stack selected by mode (zero for an unused mode code).
   always_comb begin
      peek_out_0 = '0;
      peek_out_1 = '0;
      peek_out_2 = '0;
      peek_out_3 = '0;
      depth_out  = '0;
      for (int i = 0; i < NUM_STACKS; i++) begin
         if (mode == SEL_W'(i)) begin
            peek_out_0 = top_s[i][0];
            peek_out_1 = top_s[i][1];
            peek_out_2 = top_s[i][2];
            peek_out_3 = top_s[i][3];
            depth_out  = {1'b0, sp_s[i]} + DEP_W'(1);
         end else begin
            depth_out = depth_out;
         end
      end
   end

`ifdef MATRIX_STACK_ERR_EN
   logic ovf_q, ovf_d, unf_q, unf_d;

   // Sticky flags; LOAD_ID to any stack clears both.
   always_comb begin
      if (ld_id_s) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else begin
         ovf_d = ovf_q | (|ovf_evt_s);
         unf_d = unf_q | (|unf_evt_s);
      end
   end

   // Error flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`else
   logic unused_evt_s;
   assign unused_evt_s = |{ovf_evt_s, unf_evt_s};
   assign overflow     = 1'b0;
   assign underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_stack.sv
// tb_matrix_stack -- randomized self-checking bench for matrix_stack with a
// behavioural model (arrays of matrices plus a pointer per stack).
module tb_matrix_stack;

   localparam int ROW_W = 128;
   localparam int DEPTH = 32;
   localparam int NS    = 2;
`ifdef MATRIX_STACK_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam logic [2:0] C_LOAD_ID = 3'd1, C_LOAD = 3'd2, C_PUSH = 3'd3, C_POP = 3'd4, C_WRITE = 3'd5;
   localparam logic [127:0] I0 = 128'h3F800000_00000000_00000000_00000000;
   localparam logic [127:0] I1 = 128'h00000000_3F800000_00000000_00000000;
   localparam logic [127:0] I2 = 128'h00000000_00000000_3F800000_00000000;
   localparam logic [127:0] I3 = 128'h00000000_00000000_00000000_3F800000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [0:0] mode = 1'b0;
   logic cmd_valid = 1'b0;
   logic [2:0] cmd_op = 3'd0;
   logic cmd_ready;
   logic [ROW_W-1:0] data_in = '0;
   logic data_valid = 1'b0;
   logic [ROW_W-1:0] write_in_0 = '0, write_in_1 = '0, write_in_2 = '0, write_in_3 = '0;
   logic [ROW_W-1:0] peek_out_0, peek_out_1, peek_out_2, peek_out_3;
   logic [5:0] depth_out;
   logic overflow, underflow;

   int n_chk = 0;
   int n_fail = 0;

   matrix_stack #(.ROW_W(ROW_W), .DEPTH(DEPTH), .NUM_STACKS(NS)) dut (
      .clk(clk), .rst(rst), .mode(mode), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_ready(cmd_ready), .data_in(data_in), .data_valid(data_valid),
      .write_in_0(write_in_0), .write_in_1(write_in_1), .write_in_2(write_in_2),
      .write_in_3(write_in_3), .peek_out_0(peek_out_0), .peek_out_1(peek_out_1),
      .peek_out_2(peek_out_2), .peek_out_3(peek_out_3), .depth_out(depth_out),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [127:0] m_mem [NS][DEPTH][4];
   int m_sp [NS];
   bit m_ovf, m_unf, m_busy;
   int m_row, m_tgt;

   function automatic logic [127:0] ident(int r);
      logic [127:0] v;
      v = '0;
      v[127 - 32*r -: 32] = 32'h3F80_0000;
      return v;
   endfunction

   function automatic logic [127:0] wr_in(int r);
      case (r)
         0: return write_in_0;
         1: return write_in_1;
         2: return write_in_2;
         default: return write_in_3;
      endcase
   endfunction

   function automatic logic [127:0] peek(int r);
      case (r)
         0: return peek_out_0;
         1: return peek_out_1;
         2: return peek_out_2;
         default: return peek_out_3;
      endcase
   endfunction

   task automatic m_reset();
      for (int s = 0; s < NS; s++) begin
         m_sp[s] = 0;
         for (int e = 0; e < DEPTH; e++)
            for (int r = 0; r < 4; r++) m_mem[s][e][r] = ident(r);
      end
      m_ovf = 1'b0; m_unf = 1'b0; m_busy = 1'b0; m_row = 0; m_tgt = 0;
   endtask

   // Apply what the DUT sees at this rising edge.
   task automatic m_step();
      int md;
      md = int'(mode);
      if (rst) return;
      if (m_busy) begin
         if (data_valid) begin
            m_mem[m_tgt][m_sp[m_tgt]][m_row] = data_in;
            m_row++;
            if (m_row == 4) m_busy = 1'b0;
         end
      end else if (cmd_valid) begin
         case (cmd_op)
            C_LOAD_ID: begin
               for (int r = 0; r < 4; r++) m_mem[md][m_sp[md]][r] = ident(r);
               m_ovf = 1'b0; m_unf = 1'b0;
            end
            C_LOAD: begin m_busy = 1'b1; m_row = 0; m_tgt = md; end
            C_PUSH: begin
               if (m_sp[md] == DEPTH - 1) m_ovf = ERR_EN;
               else begin
                  for (int r = 0; r < 4; r++) m_mem[md][m_sp[md]+1][r] = m_mem[md][m_sp[md]][r];
                  m_sp[md]++;
               end
            end
            C_POP: begin
               if (m_sp[md] == 0) m_unf = ERR_EN;
               else m_sp[md]--;
            end
            C_WRITE: for (int r = 0; r < 4; r++) m_mem[md][m_sp[md]][r] = wr_in(r);
            default: ;
         endcase
      end
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (!rst) begin
         for (int r = 0; r < 4; r++) chk("model_peek", peek(r), m_mem[int'(mode)][m_sp[int'(mode)]][r]);
         chk("model_depth", 128'(depth_out), 128'(m_sp[int'(mode)] + 1));
         chk("model_ready", 128'(cmd_ready), 128'(!m_busy));
         chk("model_ovf", 128'(overflow), 128'(m_ovf));
         chk("model_unf", 128'(underflow), 128'(m_unf));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic cmd(input logic [2:0] op, input logic md);
      mode = md; cmd_op = op; cmd_valid = 1'b1;
      cyc();
      cmd_valid = 1'b0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk_id(input string nm);
      chk({nm, "_r0"}, peek_out_0, I0);
      chk({nm, "_r1"}, peek_out_1, I1);
      chk({nm, "_r2"}, peek_out_2, I2);
      chk({nm, "_r3"}, peek_out_3, I3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] rows [4];
      logic [127:0] beat [6];
      bit           bv [6];
      int           low_cnt;

      m_reset();
      // Reset state, checked while rst is held.
      #12;
      mode = 1'b0; #1; chk_id("rst_m0");
      chk("rst_depth", 128'(depth_out), 128'd1);
      chk("rst_ready", 128'(cmd_ready), 128'd1);
      chk("rst_ovf", 128'(overflow), 128'd0);
      mode = 1'b1; #1; chk_id("rst_m1");
      @(negedge clk); rst = 1'b0; mode = 1'b0;

      // LOAD A,B,C,D with a two-cycle gap after B.
      for (int r = 0; r < 4; r++) rows[r] = rnd128();
      beat = '{rows[0], rows[1], 128'h0, 128'h0, rows[2], rows[3]};
      bv   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      cmd(C_LOAD, 1'b0);
      low_cnt = cmd_ready ? 0 : 1;
      for (int i = 0; i < 6; i++) begin
         data_valid = bv[i]; data_in = beat[i];
         cyc();
         if (!cmd_ready) low_cnt++;
      end
      data_valid = 1'b0;
      chk("load_busy_cycles", 128'(low_cnt), 128'd6);
      chk("load_r0", peek_out_0, rows[0]);
      chk("load_r1", peek_out_1, rows[1]);
      chk("load_r2", peek_out_2, rows[2]);
      chk("load_r3", peek_out_3, rows[3]);
      chk("load_depth", 128'(depth_out), 128'd1);

      // PUSH, WRITE identity, POP.
      cmd(C_PUSH, 1'b0);
      chk("push_depth", 128'(depth_out), 128'd2);
      chk("push_copy_r2", peek_out_2, rows[2]);
      write_in_0 = I0; write_in_1 = I1; write_in_2 = I2; write_in_3 = I3;
      cmd(C_WRITE, 1'b0);
      chk_id("write_id");
      cmd(C_POP, 1'b0);
      chk("pop_depth", 128'(depth_out), 128'd1);
      chk("pop_r0", peek_out_0, rows[0]);
      chk("pop_r3", peek_out_3, rows[3]);
      mode = 1'b1; #1; chk_id("stack1_untouched");

      // Fill stack 1, then overflow.
      for (int i = 0; i < 31; i++) cmd(C_PUSH, 1'b1);
      chk("full_depth", 128'(depth_out), 128'd32);
      cmd(C_PUSH, 1'b1);
      chk("ovf_depth", 128'(depth_out), 128'd32);
      chk("ovf_flag", 128'(overflow), 128'(ERR_EN));
      cmd(C_POP, 1'b1);
      chk("ovf_pop_depth", 128'(depth_out), 128'd31);
      chk("ovf_sticky", 128'(overflow), 128'(ERR_EN));

      // Drain to depth 1, then underflow.
      for (int i = 0; i < 30; i++) cmd(C_POP, 1'b1);
      chk("drain_depth", 128'(depth_out), 128'd1);
      cmd(C_POP, 1'b1);
      chk("unf_depth", 128'(depth_out), 128'd1);
      chk("unf_flag", 128'(underflow), 128'(ERR_EN));
      chk_id("unf_contents");
      cmd(C_LOAD_ID, 1'b0);
      chk("ldid_clr_unf", 128'(underflow), 128'd0);
      chk("ldid_clr_ovf", 128'(overflow), 128'd0);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         mode       = 1'($urandom_range(0, 1));
         cmd_valid  = ($urandom_range(0, 2) != 0);
         cmd_op     = ($urandom_range(0, 3) == 0) ? C_PUSH : 3'($urandom_range(0, 7));
         data_valid = 1'($urandom_range(0, 1));
         data_in    = rnd128();
         write_in_0 = rnd128(); write_in_1 = rnd128();
         write_in_2 = rnd128(); write_in_3 = rnd128();
         cyc();
      end
      cmd_valid = 1'b0; data_valid = 1'b0;
      while (!cmd_ready) begin
         data_valid = 1'b1; data_in = rnd128();
         cyc();
      end
      data_valid = 1'b0;

      // Reset in the middle of a LOAD.
      cmd(C_LOAD, 1'b0);
      for (int i = 0; i < 2; i++) begin
         data_valid = 1'b1; data_in = rnd128();
         cyc();
      end
      data_valid = 1'b0;
      #2; rst = 1'b1; m_reset();
      #1;
      chk("midrst_ready", 128'(cmd_ready), 128'd1);
      chk("midrst_depth", 128'(depth_out), 128'd1);
      chk_id("midrst_peek");
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data_valid = 1'b1; data_in = rnd128();
         cyc();
      end
      data_valid = 1'b0;
      chk_id("postrst_peek");
      chk("postrst_ready", 128'(cmd_ready), 128'd1);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
